// File: rtl/pulse_extender_multi_if.sv
// Bundle of per-channel strobes, shared controls and extended outputs for pulse_extender_multi.
// The master side drives the strobes and controls; the slave side is the extender itself.
interface pulse_extender_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0] pulse_in;
    logic [CNT_W-1:0]    ext_len;
    logic                retrigger;
    logic                clr_missed;
    logic [CHANNELS-1:0] extended_pulse;
    logic [CHANNELS-1:0] missed;
    logic                busy;

    modport master (
        output pulse_in,
        output ext_len,
        output retrigger,
        output clr_missed,
        input  extended_pulse,
        input  missed,
        input  busy
    );

    modport slave (
        input  pulse_in,
        input  ext_len,
        input  retrigger,
        input  clr_missed,
        output extended_pulse,
        output missed,
        output busy
    );
endinterface

// File: rtl/pulse_extender_multi.sv
// Multi-channel rising-edge pulse extender with retrigger or one-shot behaviour per shared mode.
// Each channel stretches an input edge into a registered pulse of ext_len cycles (0 acts as 1).
module pulse_extender_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_extender_multi_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              state_q   [CHANNELS];
    state_t              state_nxt [CHANNELS];
    logic [CNT_W-1:0]    cnt_q     [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt   [CHANNELS];

    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] missed_q;
    logic [CHANNELS-1:0] missed_nxt;
    logic [CHANNELS-1:0] missed_set;
    logic [CHANNELS-1:0] ext_q;
    logic [CHANNELS-1:0] active_nxt;
    logic [CHANNELS-1:0] edge_det;
    logic                busy_q;
    logic [CNT_W-1:0]    load_val;

    assign edge_det = bus.pulse_in & ~prev_q;

    // The counter holds "cycles remaining after this one", so a length of L loads L-1.
    assign load_val = (bus.ext_len == '0) ? '0 : bus.ext_len - 1'b1;

    // At terminal count the channel is effectively idle, so a coincident edge reloads
    // even in one-shot mode and produces a gapless back-to-back pulse.
    always_comb begin
        active_nxt = '0;
        missed_set = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_nxt[i] = state_q[i];
            cnt_nxt[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (edge_det[i]) begin
                        state_nxt[i] = ACTIVE;
                        cnt_nxt[i]   = load_val;
                    end
                end
                ACTIVE: begin
                    if (edge_det[i] && (bus.retrigger || cnt_q[i] == '0)) begin
                        cnt_nxt[i] = load_val;
                    end else begin
                        missed_set[i] = edge_det[i];
                        if (cnt_q[i] == '0) begin
                            state_nxt[i] = IDLE;
                        end else begin
                            cnt_nxt[i] = cnt_q[i] - 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
            active_nxt[i] = (state_nxt[i] == ACTIVE);
        end
    end

    // A new drop in the same cycle as clr_missed keeps the flag set.
    assign missed_nxt = missed_set | (missed_q & ~{CHANNELS{bus.clr_missed}});

    // prev resets high so an input already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= '1;
            missed_q <= '0;
            ext_q    <= '0;
            busy_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q   <= bus.pulse_in;
            missed_q <= missed_nxt;
            ext_q    <= active_nxt;
            busy_q   <= |active_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_nxt[i];
                cnt_q[i]   <= cnt_nxt[i];
            end
        end
    end

    assign bus.extended_pulse = ext_q;
    assign bus.missed         = missed_q;
    assign bus.busy           = busy_q;

endmodule

// File: doc/pulse_extender_multi.md
# pulse_extender_multi

Parametrised, multi-channel successor to the single-channel pulse extender. Each channel detects a rising edge on its input and drives a registered output high for a programmable number of `clk` cycles. All timing runs on the single system clock; no divided clock is needed. Selectable retrigger mode extends an active pulse. Non-retrigger mode ignores edges during an active pulse and flags them. Sits between short strobe sources (sensor/event lines, already synchronous to `clk`) and slower consumers that need a guaranteed minimum pulse width.

## Interface
- `CHANNELS`, 4: number of independent channels (≥1).
- `CNT_W`, 8: width of the length field and per-channel counter (≥2).
- `clk` in 1: system clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pulse_in` in CHANNELS: per-channel input pulses, synchronous to `clk`.
- `ext_len` in CNT_W: extension length L in cycles, shared by all channels; 0 is treated as 1.
- `retrigger` in 1: 1 = retrigger mode, 0 = one-shot mode; shared.
- `clr_missed` in 1: single-cycle clear of all `missed` flags.
- `extended_pulse` out CHANNELS: registered extended outputs.
- `missed` out CHANNELS: sticky flag, edge dropped in one-shot mode.
- `busy` out 1: OR of all `extended_pulse` bits, registered.

## Operation
- Per-channel state: `prev` (last sampled `pulse_in`), `cnt` (CNT_W bits), and a 2-state FSM (IDLE, ACTIVE). `extended_pulse[i]` = 1 exactly when the channel is ACTIVE.
- Edge detection: `edge[i] = pulse_in[i] & ~prev[i]`, evaluated at each rising edge. `prev[i] <= pulse_in[i]` every cycle.
- Effective length `Le = (ext_len == 0) ? 1 : ext_len`, sampled only at the cycle a (re)load occurs.
- IDLE, with edge: go ACTIVE and set `cnt <= Le - 1`.
- IDLE, no edge: stay IDLE.
- ACTIVE, with edge and `retrigger = 1`: reload `cnt <= Le - 1` and stay ACTIVE. The pulse ends Le cycles after the latest edge.
- ACTIVE, with edge and `retrigger = 0`: ignore the edge for timing and set `missed[i] <= 1`.
- ACTIVE, otherwise: if `cnt == 0`, go IDLE; else `cnt <= cnt - 1`.
- Terminal count and new edge in the same cycle: the edge wins. With `retrigger = 0` the channel reloads, because it is effectively IDLE at that boundary and `missed` is not set. This gives a back-to-back pulse with no gap.
- `missed`: set-dominant over `clr_missed` when both occur in the same cycle. Cleared by `rst` or by `clr_missed` otherwise.
- Channels are fully independent. Only `ext_len`, `retrigger` and `clr_missed` are shared.
- `ext_len` or `retrigger` changing while a channel is ACTIVE does not alter its running count. It only affects the next load.
- Input held high produces one edge only. No retrigger occurs until the input is low for at least one sampled cycle.

## Timing
- Reset values: `extended_pulse` = 0, `missed` = 0, `busy` = 0, all FSMs IDLE, `cnt` = 0. `prev` resets to all-ones, so an input already high at reset release does not trigger.
- `rst` mid-pulse: the output drops after the next rising edge with `rst` high, and the counter is discarded.
- Latency: edge sampled at clock edge k. `extended_pulse[i]` is 1 from after edge k to after edge k+Le, then 0. This is exactly Le cycles high, with 1 cycle of latency.
- Maximum L is 2^CNT_W − 1.
- `busy` is registered from the next-state outputs, so it is cycle-aligned with `extended_pulse`.

## Test plan
- Reset and idle: hold `rst` for 3 cycles with `pulse_in` = 4'b1111 → all outputs 0. After release, no pulse fires while the inputs stay high.
- Basic extension: L = 5, retrigger = 0, one-cycle pulse on ch0 sampled at edge k → `extended_pulse[0]` high for exactly 5 cycles starting after edge k. Other channels stay 0 and `busy` matches.
- Retrigger: L = 5, retrigger = 1, edges at k and k+3 → high for 8 cycles total (ends after edge k+8). `missed` = 0.
- One-shot drop: L = 5, retrigger = 0, edges at k and k+3 → high for 5 cycles and `missed[0]` = 1. `clr_missed` at k+10 clears it.
- Boundaries: L = 0 → 1-cycle pulse. L = 255 → 255-cycle pulse. An edge coinciding with terminal count (L = 4, edges at k and k+4) → continuous 8-cycle high with `missed` = 0.
- Multi-channel and reset mid-pulse: edges on ch1 and ch3 at different cycles → independent correct widths. `rst` asserted mid-pulse → all outputs 0 after the next edge.
